ir_err_compute: RTL

- Sequential front end that produces the signed 12-bit steering error consumed by the PID P/I/D term blocks.
- Steps an external sensor mux through 8 IR channels, one at a time, via sel, and accumulates a signed weighted sum: right sensors positive, left sensors negative, outer sensors weighted heavier.
- Scales the finished sum to 12 bits signed and presents it with a one-cycle valid pulse.

---
 rtl/ir_err_compute.sv | 101 ++++++++++
 1 files changed

// File: rtl/ir_err_compute.sv
// rtl/ir_err_compute.sv - sequential weighted IR steering error front end
module ir_err_compute #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [11:0] IR_val,
    output logic [2:0]  sel,
    output logic        busy,
    output logic [11:0] error,
    output logic        err_vld
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [2:0]         sel_q, sel_d;
    logic signed [16:0] acc_q, acc_d;
    logic [11:0]        err_q, err_d;
    logic               vld_q, vld_d;

    logic signed [16:0] mag;
    logic signed [16:0] term;
    logic signed [16:0] acc_sum;

    // Weight the current reading: magnitude 1<<sel[2:1], left sensors (odd sel) negative
    always_comb begin
        mag     = {5'b0, IR_val} << sel_q[2:1];
        term    = sel_q[0] ? -mag : mag;
        acc_sum = acc_q + term;
    end

    // Next-state: settle counting, sampling on the settle terminal count, completion on sel=7
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        acc_d   = acc_q;
        err_d   = err_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (strt_cnv) begin
                    state_d = CONV;
                    cnt_d   = 4'd0;
                    sel_d   = 3'd0;
                    acc_d   = '0;
                end
            end
            CONV: begin
                if (cnt_q == SETTLE_C) begin
                    cnt_d = 4'd0;
                    acc_d = acc_sum;
                    sel_d = sel_q + 3'd1;
                    if (sel_q == 3'd7) begin
                        // Only the finished sum ever reaches error; floor shift by 5
                        state_d = IDLE;
                        sel_d   = 3'd0;
                        err_d   = acc_sum[16:5];
                        vld_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; asynchronous reset discards any partial conversion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 3'd0;
            acc_q   <= '0;
            err_q   <= 12'd0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end

    assign sel     = sel_q;
    assign busy    = (state_q == CONV);
    assign error   = err_q;
    assign err_vld = vld_q;

endmodule
